// File: rtl/saph_defines.sv
// Shared types for the saph FPU interface blocks.
// Float carrier type and the FPU mode encoding.
package saph_defines;

  typedef logic [31:0] float_t;

  typedef enum logic [1:0] {
    FPU_ADD = 2'd0,
    FPU_SUB = 2'd1,
    FPU_MUL = 2'd2,
    FPU_DIV = 2'd3
  } fpu_mode_t;

  function automatic logic mode_ok(
    input logic [3:0] mask,
    input fpu_mode_t  mode
  );
    return mask[mode];
  endfunction

endpackage

// File: rtl/saph_rr_arbiter.sv
// N-way round-robin arbiter with hold-on-block.
// Ports: req (eligible), allow (grant permitted), win_vld/win_idx, gnt.
module saph_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  allow,
  output logic          win_vld,
  output logic [IW-1:0] win_idx,
  output logic [N-1:0]  gnt
);

  logic [IW-1:0] ptr;
  int            j;

  // First eligible requester after ptr wins, even if it
  // cannot be granted: lower priorities are not skipped.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!win_vld && req[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (win_vld && allow[win_idx])
      gnt[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= IW'(N - 1);
    else if (|gnt)
      ptr <= win_idx;
  end

endmodule

// File: rtl/saph_fpi_arbiter.sv
// Shares one FPU among N_REQ requesters with round-robin
// arbitration and a tag FIFO routing in-order results back.
// Ports: req_* requester side, rsp_* results/rejects,
// fpu_d_* FPU request, fpu_q_* FPU result, err_orphan sticky.
module saph_fpi_arbiter
  import saph_defines::*;
#(
  parameter int N_REQ = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_trig,
  input  float_t [N_REQ-1:0]       req_lhs,
  input  float_t [N_REQ-1:0]       req_rhs,
  input  logic [N_REQ-1:0][1:0]    req_mode,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_trig,
  output logic [N_REQ-1:0]         rsp_err,
  output float_t                   rsp_res,
  output logic                     fpu_d_trig,
  output float_t                   fpu_d_lhs,
  output float_t                   fpu_d_rhs,
  output logic [1:0]               fpu_d_mode,
  input  logic                     fpu_d_ready,
  input  logic                     fpu_q_trig,
  input  float_t                   fpu_q_res,
  input  logic [3:0]               fpu_has_modes,
  output logic                     err_orphan
);

  localparam int TAG_W = $clog2(N_REQ);
  localparam int PW    = $clog2(DEPTH);

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] sup;
  logic [N_REQ-1:0] allow;
  logic [N_REQ-1:0] gnt;
  logic             win_vld;
  logic [TAG_W-1:0] win_idx;

  logic [TAG_W-1:0] tags [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             rej;
  logic             orphan;
  logic [N_REQ-1:0] pop_oh;

  assign full  = (count == (PW + 1)'(DEPTH));
  assign empty = (count == '0);

  // Requests are masked while in reset so every
  // combinational output drops together with the registers.
  // Slot availability uses the current count only.
  always_comb begin
    elig  = '0;
    sup   = '0;
    allow = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i]  = req_trig[i] & rst_n;
      sup[i]   = mode_ok(fpu_has_modes, fpu_mode_t'(req_mode[i]));
      allow[i] = !sup[i] || (fpu_d_ready && !full);
    end
  end

  saph_rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (elig),
    .allow   (allow),
    .win_vld (win_vld),
    .win_idx (win_idx),
    .gnt     (gnt)
  );

  assign req_ready = gnt;
  assign push      = |gnt && sup[win_idx];
  assign rej       = |gnt && !sup[win_idx];
  assign pop       = fpu_q_trig && !empty;
  assign orphan    = fpu_q_trig && empty;

  assign fpu_d_trig = push;

  always_comb begin
    fpu_d_lhs  = '0;
    fpu_d_rhs  = '0;
    fpu_d_mode = '0;
    if (win_vld) begin
      fpu_d_lhs  = req_lhs[win_idx];
      fpu_d_rhs  = req_rhs[win_idx];
      fpu_d_mode = req_mode[win_idx];
    end
  end

  always_comb begin
    pop_oh = '0;
    pop_oh[tags[rd_ptr]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        tags[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= win_idx;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_trig   <= '0;
      rsp_err    <= '0;
      rsp_res    <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_trig   <= pop ? pop_oh : '0;
      rsp_err    <= rej ? gnt : '0;
      err_orphan <= err_orphan | orphan;
      if (pop)
        rsp_res <= fpu_q_res;
    end
  end

endmodule

// File: tb/tb_saph_fpi_arbiter.sv
// Directed self-checking bench for saph_fpi_arbiter.
// Each task drives one scenario and checks inline.
module tb_saph_fpi_arbiter;
  import saph_defines::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_trig;
  float_t [3:0]     req_lhs;
  float_t [3:0]     req_rhs;
  logic [3:0][1:0]  req_mode;
  logic [3:0]       req_ready;
  logic [3:0]       rsp_trig;
  logic [3:0]       rsp_err;
  float_t           rsp_res;
  logic             fpu_d_trig;
  float_t           fpu_d_lhs;
  float_t           fpu_d_rhs;
  logic [1:0]       fpu_d_mode;
  logic             fpu_d_ready;
  logic             fpu_q_trig;
  float_t           fpu_q_res;
  logic [3:0]       fpu_has_modes;
  logic             err_orphan;

  int n_cmp = 0;
  int n_bad = 0;

  saph_fpi_arbiter #(.N_REQ(4), .DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_trig      (req_trig),
    .req_lhs       (req_lhs),
    .req_rhs       (req_rhs),
    .req_mode      (req_mode),
    .req_ready     (req_ready),
    .rsp_trig      (rsp_trig),
    .rsp_err       (rsp_err),
    .rsp_res       (rsp_res),
    .fpu_d_trig    (fpu_d_trig),
    .fpu_d_lhs     (fpu_d_lhs),
    .fpu_d_rhs     (fpu_d_rhs),
    .fpu_d_mode    (fpu_d_mode),
    .fpu_d_ready   (fpu_d_ready),
    .fpu_q_trig    (fpu_q_trig),
    .fpu_q_res     (fpu_q_res),
    .fpu_has_modes (fpu_has_modes),
    .err_orphan    (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    req_trig      = 4'hF;
    fpu_d_ready   = 1'b1;
    fpu_q_trig    = 1'b0;
    fpu_q_res     = '0;
    fpu_has_modes = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_lhs[i]  = 32'h1000 + i;
      req_rhs[i]  = 32'h2000 + i;
      req_mode[i] = 2'd0;
    end
    #2;
    n_cmp++;
    if (req_ready !== 4'b0 || fpu_d_trig !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_req: ready=%b trig=%b want 0",
               req_ready, fpu_d_trig);
    end
    n_cmp++;
    if (rsp_trig !== 4'b0 || rsp_err !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_rsp: trig=%b err=%b want 0",
               rsp_trig, rsp_err);
    end
    n_cmp++;
    if (rsp_res !== 32'h0 || err_orphan !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_res: res=%h orph=%b want 0",
               rsp_res, err_orphan);
    end
    req_trig = 4'h0;
    step();
    step();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    int g;
    req_trig    = 4'hF;
    fpu_d_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      g          = c % 4;
      fpu_q_trig = (c >= 1);
      fpu_q_res  = 32'hA000_0000 + c;
      #1;
      n_cmp++;
      if (req_ready !== 4'(1 << g) || fpu_d_trig !== 1'b1) begin
        n_bad++;
        $display("FAIL fair_grant c=%0d: ready=%b trig=%b want %b 1",
                 c, req_ready, fpu_d_trig, 4'(1 << g));
      end
      n_cmp++;
      if (fpu_d_lhs !== 32'h1000 + g
          || fpu_d_rhs !== 32'h2000 + g) begin
        n_bad++;
        $display("FAIL fair_ops c=%0d: lhs=%h rhs=%h want %h %h",
                 c, fpu_d_lhs, fpu_d_rhs, 32'h1000 + g, 32'h2000 + g);
      end
      step();
      if (c >= 1) begin
        n_cmp++;
        if (rsp_trig !== 4'(1 << ((c - 1) % 4))
            || rsp_res !== 32'hA000_0000 + c) begin
          n_bad++;
          $display("FAIL fair_rsp c=%0d: trig=%b res=%h want %b %h",
                   c, rsp_trig, rsp_res, 4'(1 << ((c - 1) % 4)),
                   32'hA000_0000 + c);
        end
      end
    end
    req_trig   = 4'h0;
    fpu_q_trig = 1'b1;
    fpu_q_res  = 32'hB000_0000;
    step();
    fpu_q_trig = 1'b0;
    n_cmp++;
    if (rsp_trig !== 4'b1000 || rsp_res !== 32'hB000_0000) begin
      n_bad++;
      $display("FAIL fair_last: trig=%b res=%h want 1000 b0000000",
               rsp_trig, rsp_res);
    end
    step();
    n_cmp++;
    if (rsp_trig !== 4'b0 || rsp_res !== 32'hB000_0000) begin
      n_bad++;
      $display("FAIL fair_hold: trig=%b res=%h want 0000 b0000000",
               rsp_trig, rsp_res);
    end
  endtask

  task automatic test_unsupported();
    fpu_has_modes = 4'b0011;
    req_mode[2]   = 2'd3;
    req_trig      = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100 || fpu_d_trig !== 1'b0) begin
      n_bad++;
      $display("FAIL unsup_grant: ready=%b trig=%b want 0100 0",
               req_ready, fpu_d_trig);
    end
    n_cmp++;
    if (fpu_d_lhs !== 32'h1002 || fpu_d_mode !== 2'd3) begin
      n_bad++;
      $display("FAIL unsup_ops: lhs=%h mode=%0d want 1002 3",
               fpu_d_lhs, fpu_d_mode);
    end
    step();
    req_trig = 4'h0;
    n_cmp++;
    if (rsp_err !== 4'b0100 || rsp_trig !== 4'b0) begin
      n_bad++;
      $display("FAIL unsup_err: err=%b trig=%b want 0100 0000",
               rsp_err, rsp_trig);
    end
    step();
    n_cmp++;
    if (rsp_err !== 4'b0) begin
      n_bad++;
      $display("FAIL unsup_pulse: err=%b want 0000", rsp_err);
    end
    fpu_has_modes = 4'hF;
    req_mode[2]   = 2'd0;
  endtask

  task automatic test_fifo_full();
    int g;
    req_trig = 4'hF;
    for (int k = 0; k < 4; k++) begin
      g = (3 + k) % 4;
      #1;
      n_cmp++;
      if (req_ready !== 4'(1 << g) || fpu_d_trig !== 1'b1) begin
        n_bad++;
        $display("FAIL full_fill k=%0d: ready=%b trig=%b want %b 1",
                 k, req_ready, fpu_d_trig, 4'(1 << g));
      end
      step();
    end
    fpu_q_trig = 1'b1;
    fpu_q_res  = 32'hC000_0000;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0 || fpu_d_trig !== 1'b0) begin
      n_bad++;
      $display("FAIL full_block: ready=%b trig=%b want 0000 0",
               req_ready, fpu_d_trig);
    end
    step();
    fpu_q_trig = 1'b0;
    n_cmp++;
    if (rsp_trig !== 4'b1000 || rsp_res !== 32'hC000_0000) begin
      n_bad++;
      $display("FAIL full_pop: trig=%b res=%h want 1000 c0000000",
               rsp_trig, rsp_res);
    end
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_bad++;
      $display("FAIL full_regrant: ready=%b want 1000", req_ready);
    end
    step();
    req_trig = 4'h0;
    for (int k = 0; k < 4; k++) begin
      fpu_q_trig = 1'b1;
      fpu_q_res  = 32'hD000_0000 + k;
      step();
      n_cmp++;
      if (rsp_trig !== 4'(1 << k) || rsp_res !== 32'hD000_0000 + k) begin
        n_bad++;
        $display("FAIL full_drain k=%0d: trig=%b res=%h want %b %h",
                 k, rsp_trig, rsp_res, 4'(1 << k), 32'hD000_0000 + k);
      end
    end
    fpu_q_trig = 1'b0;
  endtask

  task automatic test_blocked();
    req_trig    = 4'b1010;
    fpu_d_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0 || fpu_d_lhs !== 32'h1001) begin
        n_bad++;
        $display("FAIL blk_hold k=%0d: ready=%b lhs=%h want 0000 1001",
                 k, req_ready, fpu_d_lhs);
      end
      step();
    end
    fpu_d_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL blk_first: ready=%b want 0010", req_ready);
    end
    step();
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_bad++;
      $display("FAIL blk_second: ready=%b want 1000", req_ready);
    end
    step();
    req_trig = 4'h0;
    for (int k = 0; k < 2; k++) begin
      fpu_q_trig = 1'b1;
      fpu_q_res  = 32'hE100_0000 + k;
      step();
      n_cmp++;
      if (rsp_trig !== (k == 0 ? 4'b0010 : 4'b1000)) begin
        n_bad++;
        $display("FAIL blk_route k=%0d: trig=%b want %b",
                 k, rsp_trig, (k == 0 ? 4'b0010 : 4'b1000));
      end
    end
    fpu_q_trig = 1'b0;
  endtask

  task automatic test_orphan();
    n_cmp++;
    if (err_orphan !== 1'b0) begin
      n_bad++;
      $display("FAIL orph_pre: orph=%b want 0", err_orphan);
    end
    fpu_q_trig = 1'b1;
    fpu_q_res  = 32'hEEEE_EEEE;
    step();
    fpu_q_trig = 1'b0;
    n_cmp++;
    if (rsp_trig !== 4'b0 || err_orphan !== 1'b1
        || rsp_res !== 32'hE100_0001) begin
      n_bad++;
      $display("FAIL orph_set: trig=%b orph=%b res=%h want 0000 1 e1000001",
               rsp_trig, err_orphan, rsp_res);
    end
    step();
    step();
    n_cmp++;
    if (err_orphan !== 1'b1) begin
      n_bad++;
      $display("FAIL orph_sticky: orph=%b want 1", err_orphan);
    end
  endtask

  task automatic test_reset_midflight();
    req_trig = 4'b0111;
    step();
    step();
    step();
    req_trig = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0 || fpu_d_trig !== 1'b0
        || fpu_d_lhs !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_comb: ready=%b trig=%b lhs=%h want 0",
               req_ready, fpu_d_trig, fpu_d_lhs);
    end
    n_cmp++;
    if (err_orphan !== 1'b0 || rsp_res !== 32'h0
        || rsp_trig !== 4'b0) begin
      n_bad++;
      $display("FAIL mid_regs: orph=%b res=%h trig=%b want 0",
               err_orphan, rsp_res, rsp_trig);
    end
    step();
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_first: ready=%b want 0001", req_ready);
    end
    req_trig   = 4'h0;
    fpu_q_trig = 1'b1;
    step();
    fpu_q_trig = 1'b0;
    n_cmp++;
    if (err_orphan !== 1'b1 || rsp_trig !== 4'b0) begin
      n_bad++;
      $display("FAIL mid_empty: orph=%b trig=%b want 1 0000",
               err_orphan, rsp_trig);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_unsupported();
    test_fifo_full();
    test_blocked();
    test_orphan();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/saph_fpi_arbiter.md
Name: saph_fpi_arbiter

Overview:
- Shares one FPU among N requesters, for example several shader lanes or units on one FPU.
- Requester side: N independent copies of the FPU request/result handshake. FPU side: one copy of that handshake.
- Round-robin arbitration; tag FIFO routes each in-order FPU result back to its issuer.
- Requests whose mode the FPU does not support are answered locally with an error pulse and never reach the FPU.

Parameters:
- N_REQ, 4, number of requester ports (2..16).
- DEPTH, 4, maximum FPU operations in flight (tag FIFO depth, power of two, >=2).
- TAG_W, $clog2(N_REQ), requester tag width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_trig  in  N_REQ  per-requester trigger.
- req_lhs  in  N_REQ x float  left operands.
- req_rhs  in  N_REQ x float  right operands.
- req_mode  in  N_REQ x 2  FPU mode per requester.
- req_ready  out  N_REQ  request accepted this cycle if trig&ready.
- rsp_trig  out  N_REQ  one-hot result-valid pulse.
- rsp_err  out  N_REQ  unsupported-mode reject pulse.
- rsp_res  out  float  result, broadcast to all requesters.
- fpu_d_trig  out  1  FPU trigger.
- fpu_d_lhs, fpu_d_rhs  out  float  FPU operands.
- fpu_d_mode  out  2  FPU mode.
- fpu_d_ready  in  1  FPU can accept.
- fpu_q_trig  in  1  FPU result valid.
- fpu_q_res  in  float  FPU result.
- fpu_has_modes  in  4  supported-mode mask (constant).
- err_orphan  out  1  sticky: FPU result arrived with no outstanding tag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - req_ready, rsp_trig, rsp_err, fpu_d_trig, err_orphan = 0; rsp_res = 0.
  - FIFO empty; RR pointer = N_REQ-1, so requester 0 has first priority.
  - In-flight FPU operations are forgotten. The FPU must be reset alongside.
- Eligible(i) = req_trig[i]. Supported(i) = fpu_has_modes[req_mode[i]].
- Arbitration (combinational, one grant per cycle):
  - Scan from ptr+1 cyclically; first eligible requester wins.
  - A supported winner is granted only if fpu_d_ready=1 and the FIFO count < DEPTH.
  - A same-cycle pop does not free a slot for the same-cycle grant.
  - An unsupported winner is always granted.
  - A blocked winner holds the grant; no skip to a lower-priority requester. This prevents starvation.
- req_ready[w] = grant; all other ready bits are 0.
- On any grant, ptr <= w.
- Supported grant:
  - fpu_d_trig=1 the same cycle (combinational path); fpu_d_lhs/rhs/mode = the winner's operands.
  - Push w into the FIFO.
- fpu_d_* operand outputs equal the winner's operands whenever a winner exists, otherwise 0.
- Unsupported grant: rsp_err[w]=1 on the next cycle, for one cycle. Nothing is pushed to the FIFO and the FPU is not triggered.
- fpu_q_trig=1 with the FIFO non-empty:
  - Pop tag t.
  - Next cycle: rsp_trig[t]=1 and rsp_res=fpu_q_res (registered, latency 1).
  - rsp_res holds its value until the next result.
- fpu_q_trig=1 with the FIFO empty: result dropped, err_orphan <= 1 until reset.
- Simultaneous push and pop allowed (count unchanged). rsp_err and rsp_trig may fire in the same cycle, including for the same requester.
- FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- The FPU is required to return results in issue order.

Decomposition:
- Shared package (saph_defines): float typedef; a fpu_mode_t 2-bit enum for the modes indexing fpu_has_modes.
- Sub-module: saph_rr_arbiter (N-way round-robin with hold-on-block and pointer update), reusable elsewhere.
- The tag FIFO is inline.

Test Plan:
- Fairness, no backpressure: all 4 requesters trigger continuously, fpu_d_ready=1. Grant order is 0,1,2,3,0,... Each rsp_trig arrives one cycle after the matching fpu_q_trig, with correct tag and rsp_res.
- Unsupported mode: fpu_has_modes=4'b0011, requester 2 sends mode 3. req_ready[2]=1, then rsp_err[2] pulses next cycle. fpu_d_trig stays 0 and the FIFO count is unchanged.
- FIFO full (DEPTH=4): issue 4 ops with the FPU stalled. req_ready stays 0 at count=4. After one fpu_q_trig, the next cycle grants again; the result routes to the first-issued tag.
- Blocked winner: requester 1 supported but fpu_d_ready=0, requester 3 also triggering. Neither is granted until ready rises, then 1 is granted before 3.
- Orphan result: pulse fpu_q_trig with an empty FIFO. No rsp_trig fires, and err_orphan=1 and stays set until rst_n falls.
- Reset mid-flight: 3 ops outstanding, assert rst_n=0 asynchronously. All outputs drop immediately, the FIFO is empty after release, and requester 0 is granted first.
